// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, then shifts a start bit, eight
// data bits (LSB first), odd parity and a stop bit on device clocks, then checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK_WAIT, WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  logic             clk_s1, clk_s2, clk_s3;
  logic             data_s1, data_s2;
  logic             fe;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       tx_byte;
  logic             parity_q;
  logic             drive_q, drive_nxt;
  logic             ack_bit;
  logic             done_nxt, err_nxt, tout_nxt;
  logic             accept, to_hit;

  // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fe     = clk_s3 & ~clk_s2;
  assign accept = tx_valid && (state == IDLE);
  assign to_hit = (state != IDLE) && (state != INHIBIT) && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    drive_nxt = drive_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    tout_nxt  = 1'b0;
    if (to_hit) begin
      // Timeout wins over any falling edge seen in the same cycle.
      state_nxt = IDLE;
      drive_nxt = 1'b0;
      tout_nxt  = 1'b1;
    end else begin
      case (state)
        IDLE:      if (accept) state_nxt = INHIBIT;
        INHIBIT:   if (inh_cnt == INH_LAST) begin
                     state_nxt = START;
                     drive_nxt = 1'b1;
                   end
        START:     if (fe) begin
                     state_nxt = DATA;
                     drive_nxt = ~tx_byte[0];
                   end
        DATA:      if (fe) begin
                     if (bit_cnt == 4'd7) begin
                       state_nxt = PARITY;
                       drive_nxt = ~parity_q;
                     end else begin
                       drive_nxt = ~tx_byte[bit_cnt[2:0] + 3'd1];
                     end
                   end
        PARITY:    if (fe) begin
                     state_nxt = STOP;
                     drive_nxt = 1'b0;
                   end
        STOP:      if (fe) state_nxt = ACK_WAIT;
        ACK_WAIT:  if (ack_bit) begin
                     state_nxt = IDLE;
                     err_nxt   = 1'b1;
                   end else begin
                     state_nxt = WAIT_IDLE;
                   end
        WAIT_IDLE: if (clk_s2 && data_s2) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                   end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      tx_byte  <= '0;
      parity_q <= 1'b0;
      drive_q  <= 1'b0;
      ack_bit  <= 1'b1;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      drive_q <= drive_nxt;
      done    <= done_nxt;
      ack_err <= err_nxt;
      timeout <= tout_nxt;
      if (accept) begin
        tx_byte  <= tx_data;
        parity_q <= ~^tx_data;
      end
      inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      to_cnt  <= (state == IDLE || state == INHIBIT) ? '0 : to_cnt + 1'b1;
      if (state != DATA)
        bit_cnt <= '0;
      else if (fe)
        bit_cnt <= bit_cnt + 4'd1;
      // The ACK level is captured on the eleventh falling edge, while still in STOP.
      if (state == STOP && fe)
        ack_bit <= data_s2;
    end
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = ((state == INHIBIT) && (inh_cnt == INH_LAST)) | drive_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same ps2_clk/ps2_data pins the keyboard receiver listens on.
- Implements the full host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, device ACK.
- Drives the lines open-drain via active-high pull-low enables; the top level ties the pads low when an enable is 1 and releases them otherwise.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to ACK completion (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin level.
- ps2_data  in  1  raw PS/2 data pin level.
- tx_data  in  8  byte to send.
- tx_valid  in  1  send request.
- tx_ready  out  1  high when IDLE and able to accept.
- ps2_clk_oe  out  1  1 = pull ps2_clk low.
- ps2_data_oe  out  1  1 = pull ps2_data low.
- busy  out  1  high in any state other than IDLE; the receiver ignores frames while busy.
- done  out  1  one-cycle pulse when a transfer ends with a good ACK.
- ack_err  out  1  one-cycle pulse when the ACK bit is sampled high.
- timeout  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high. Reset forces IDLE; all outputs are 0 except tx_ready=1; both lines are released.
- Reset mid-transfer: lines are released on the next clk edge and no done, ack_err or timeout pulse is generated.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge (fe) is registered when the previous synced clock is 1 and the current synced clock is 0. fe is therefore seen 3 clk cycles after the pin falls. Pins settle glitch-free; no debounce is required.
- Handshake:
  - A transfer is accepted when tx_valid && tx_ready.
  - tx_data is latched with parity = ~^tx_data (odd parity).
  - tx_valid while busy is ignored; no queuing.
- IDLE: clk_oe=0, data_oe=0. On accept -> INHIBIT and load a counter.
- INHIBIT:
  - clk_oe=1 for INHIBIT_CYCLES cycles.
  - data_oe=1 on the final cycle only, so data is low before the clock is released.
  - Then -> START, clear the timeout counter and the bit counter.
- START: clk_oe=0, data_oe=1 (start bit 0). On fe -> DATA, driving data_oe=~bit0.
- DATA:
  - Each fe advances the bit counter and drives data_oe=~bit[n]. Data only changes on fe, in the cycle after fe is detected.
  - After the fe that drives bit7 has passed, the next fe drives data_oe=~parity -> PARITY.
- PARITY: the next fe drives data_oe=0 (stop bit, line released) -> STOP.
- STOP: the next fe -> ACK_WAIT; the synced ps2_data is sampled in the same cycle fe is detected.
  - Sample 0 -> WAIT_IDLE.
  - Sample 1 -> pulse ack_err, -> IDLE.
- WAIT_IDLE: when synced clock and data are both 1 -> pulse done, -> IDLE. tx_ready rises in the same cycle.
- Timeout:
  - The counter runs in START through WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1: release both lines, pulse timeout, -> IDLE.
  - Timeout takes priority over an fe in the same cycle.
- Width rules: counters are sized with $clog2 of their parameter; the bit counter is 4 bits. Counters do not wrap because they are bounded by their state.
- Exactly one of done, ack_err or timeout pulses per accepted transfer, except when terminated by reset.

Test Plan:
- Basic 0xED: device model waits for clock release, clocks at 12.5 kHz, samples on rising edges and ACKs low. Required: start 0; bits 1,0,1,1,0,1,1,1 (LSB first); parity 1; stop 1; ps2_clk_oe held exactly 5000 cycles; done pulses once; tx_ready returns to 1.
- 0xFF and 0x00: parity sampled as 1 and 1 respectively, because odd parity requires 0x00 to carry parity 1 and 0xFF (eight ones) to carry parity 1.
- NACK: device leaves data high at clock 11. Required: ack_err pulses once, done stays 0, lines are released, the FSM is back in IDLE.
- Silent device (never clocks) with TIMEOUT_CYCLES=2000: timeout pulses 2000 cycles after clock release; clk_oe=0 and data_oe=0 afterwards; no done.
- clr asserted after bit 3: next cycle both oe are 0, tx_ready=1, busy=0, no pulses. A following 0xF4 transfer then completes with done.
- tx_valid held high during a transfer with different data: ignored; only the originally latched byte appears on the wire.
